stacker_core: RTL and testbench
===============================

Name: stacker_core

Overview:
- Parametrised stacker game engine: one COLS-wide slider bounces across the current row; the player drops it onto the stack below.
- Only the overlapping columns are kept, so the slider narrows on each misaligned drop. Zero overlap loses; filling all ROWS wins.
- Runs on a single system clock with tick-enable strobes instead of derived clocks.
- Drives the row-scanned LED matrix (columns active-high, rows active-low). Sits between the debounce/tick generators and the matrix pins.

Parameters:
- COLS, 8, matrix columns / slider field width.
- ROWS, 8, matrix rows / levels to win.
- INIT_WIDTH, 3, slider width at game start (1..COLS).
- FLASH_TICKS, 8, number of blink on/off pairs shown in WIN/LOSE before auto-restart.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- move_tick  in  1  one-cycle strobe; slider step.
- scan_tick  in  1  one-cycle strobe; display row advance.
- blink_tick  in  1  one-cycle strobe; flash phase toggle.
- drop  in  1  debounced one-cycle drop pulse.
- col_out  out  COLS  column drive, bit c = column c, 1 = lit.
- row_sel  out  ROWS  row drive, one-cold, 0 = selected; row 0 = bottom.
- level  out  clog2(ROWS+1)  rows already stacked.
- state  out  2  0 = PLAY, 1 = WIN, 2 = LOSE.
- width  out  clog2(COLS+1)  current slider width.

Behaviour:
- Reset is synchronous, active-high, and overrides everything, including mid-flash. Reset values:
  - state = PLAY, level = 0, width = INIT_WIDTH.
  - pos = 0, dir = up, all stack rows = 0.
  - scan row = 0, flash phase = 0, flash count = 0.
  - col_out = 0, row_sel = all ones.
- Slider mask is ((1<<width)-1) << pos; pos is the index of the lowest lit column.
- move_tick in PLAY:
  - dir up: pos+width < COLS → pos+1; otherwise dir = down and pos-1.
  - dir down: pos > 0 → pos-1; otherwise dir = up and pos+1.
  - width == COLS: pos stays 0, no movement.
- drop in PLAY:
  - below = all ones when level == 0, else stack[level-1]; ovl = mask & below.
  - ovl == 0 → state = LOSE; stack is unchanged.
  - ovl != 0 → stack[level] = ovl, width = popcount(ovl), level+1.
  - After a successful drop: pos = 0, dir = up. If level was ROWS-1, state = WIN.
  - All updates visible on the next cycle.
- drop and move_tick in the same cycle: the drop is evaluated on the pre-move mask and the move is discarded.
- WIN/LOSE:
  - drop and move_tick are ignored.
  - Each blink_tick toggles phase and increments flash count.
  - On the 2*FLASH_TICKS-th blink_tick: return to PLAY with reset values (stack cleared).
- Display content per row r:
  - r < level: stack[r].
  - r == level and state == PLAY: slider mask.
  - otherwise: 0.
  - In WIN/LOSE every row is ANDed with phase (whole image blinks). In LOSE, row `level` additionally shows the failed slider mask while phase = 1.
- Display scan:
  - scan_tick advances the scan row; wraps ROWS-1 → 0.
  - col_out and row_sel are registered and show row r one cycle after the scan change.
  - row_sel = ~(1<<r).
  - Display never blanks during a state change; next scan reflects the new state.
- level saturates at ROWS (WIN); no wrap.

Optional Feature:
- STACKER_SPEEDUP_EN defined:
  - An internal prescaler counts move_ticks; the slider steps once every max(1, ROWS-1-level) move_ticks, so speed rises with height.
  - The prescaler clears on reset, on every successful drop, and on restart.
- STACKER_SPEEDUP_EN undefined: the slider steps on every move_tick; no prescaler logic is present.

Test Plan:
1. Bounce, after reset (COLS=8, INIT_WIDTH=3): 5 move_ticks → pos 5, mask 8'b11100000. 1 more → pos 4, dir down. 4 more → pos 0. Next → pos 1, dir up.
2. First drop: pos 2, drop at level 0 → stack[0] = 8'b00011100, level 1, width 3, pos 0.
3. Trim: advance to pos 3 (mask 8'b00111000), drop → stack[1] = 8'b00011000, width 2, level 2.
4. Loss and restart: at level 2, mask 8'b00000011 vs stack[1] 8'b00011000, drop → state 2. Then 16 blink_ticks → state 0, level 0, width 3, all stack rows 0. A drop pulsed while in LOSE must be ignored.
5. Win: 8 aligned drops at pos 0 with width 3 → state 1, level 8. During flash, scanning row 7 gives col_out 8'b00000111 when phase = 1 and 0 when phase = 0.
6. Corner cases:
   - drop and move_tick in the same cycle at pos 4 → stored row uses pos 4 mask.
   - reset asserted mid-WIN flash → all reset values on the next cycle.
   - Scan: 8 scan_ticks cycle row_sel through 8'b11111110 … 8'b01111111 and back.

Source files
------------

// File: rtl/stacker_core.sv
// -----------------------------------------------------------------------------
// stacker_core
//   Stacker game engine. A slider of `width` lit columns bounces across the
//   current row; a drop keeps only the columns that overlap the row below.
//   No overlap loses; stacking ROWS rows wins. WIN/LOSE blink the image for
//   FLASH_TICKS on/off pairs and then restart automatically.
//   All timing comes from one-cycle enable strobes on the single clock `clk`.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset, overrides everything
//   move_tick   slider step strobe
//   scan_tick   display row advance strobe
//   blink_tick  flash phase toggle strobe (WIN/LOSE only)
//   drop        debounced one-cycle drop pulse
//   col_out     registered column drive, 1 = lit
//   row_sel     registered row drive, one-cold, row 0 = bottom
//   level       rows already stacked
//   state       0 = PLAY, 1 = WIN, 2 = LOSE
//   width       current slider width
//
// Optional build macro:
//   STACKER_SPEEDUP_EN  slider steps once every max(1, ROWS-1-level)
//                       move_ticks, so it speeds up as the stack grows.
// -----------------------------------------------------------------------------
module stacker_core #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int INIT_WIDTH  = 3,
    parameter int FLASH_TICKS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       move_tick,
    input  logic                       scan_tick,
    input  logic                       blink_tick,
    input  logic                       drop,
    output logic [COLS-1:0]            col_out,
    output logic [ROWS-1:0]            row_sel,
    output logic [$clog2(ROWS+1)-1:0]  level,
    output logic [1:0]                 state,
    output logic [$clog2(COLS+1)-1:0]  width
);
    localparam int LW = $clog2(ROWS + 1);
    localparam int WW = $clog2(COLS + 1);
    localparam int PW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = $clog2(2 * FLASH_TICKS + 1);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_WIN  = 2'd1,
        ST_LOSE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [LW-1:0]     level_reg;
    logic [WW-1:0]     width_reg;
    logic [PW-1:0]     pos_reg;
    logic              dir_reg;            // 1 = moving toward higher columns
    logic [COLS-1:0]   stack_reg [ROWS];
    logic              phase_reg;
    logic [FW-1:0]     flash_cnt_reg;
    logic [SW-1:0]     scan_reg;
    logic [COLS-1:0]   col_out_reg;
    logic [ROWS-1:0]   row_sel_reg;

    logic [COLS-1:0]   slider_mask;
    logic [COLS-1:0]   below;
    logic [COLS-1:0]   ovl;
    logic [WW-1:0]     ovl_count;
    logic [PW-1:0]     pos_moved;
    logic              dir_moved;
    logic              step_en;
    logic              drop_hit;
    logic              restart_now;
    logic [COLS-1:0]   row_pix;

    // Slider mask: columns pos .. pos+width-1 lit.
    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_mask
            assign slider_mask[gi] = (gi >= int'(pos_reg)) &&
                                     (gi < int'(pos_reg) + int'(width_reg));
        end
    endgenerate

    // Row below the slider; the floor counts as fully lit.
    always_comb begin
        below = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (level_reg != '0 && r == int'(level_reg) - 1)
                below = stack_reg[r];
        end
    end

    assign ovl = slider_mask & below;

    always_comb begin
        ovl_count = '0;
        for (int c = 0; c < COLS; c++)
            ovl_count = ovl_count + WW'(ovl[c]);
    end

    // Next slider position/direction for one step. A full-width slider
    // has nowhere to go and stays parked at column 0.
    always_comb begin
        pos_moved = pos_reg;
        dir_moved = dir_reg;
        if (int'(width_reg) < COLS) begin
            if (dir_reg) begin
                if (int'(pos_reg) + int'(width_reg) < COLS) begin
                    pos_moved = pos_reg + PW'(1);
                end else begin
                    dir_moved = 1'b0;
                    pos_moved = pos_reg - PW'(1);
                end
            end else begin
                if (pos_reg != '0) begin
                    pos_moved = pos_reg - PW'(1);
                end else begin
                    dir_moved = 1'b1;
                    pos_moved = pos_reg + PW'(1);
                end
            end
        end
    end

    assign drop_hit    = (state_reg == ST_PLAY) && drop && (ovl != '0);
    assign restart_now = (state_reg != ST_PLAY) && blink_tick &&
                         (flash_cnt_reg == FW'(2 * FLASH_TICKS - 1));

`ifdef STACKER_SPEEDUP_EN
    logic [LW-1:0] presc_reg;
    int            step_period;

    always_comb begin
        step_period = ROWS - 1 - int'(level_reg);
        if (step_period < 1)
            step_period = 1;
    end

    assign step_en = move_tick && (int'(presc_reg) + 1 >= step_period);

    always_ff @(posedge clk) begin
        if (reset || restart_now || drop_hit) begin
            presc_reg <= '0;
        end else if (state_reg == ST_PLAY && move_tick && !drop) begin
            presc_reg <= step_en ? '0 : presc_reg + LW'(1);
        end
    end
`else
    assign step_en = move_tick;
`endif

    // Game state. Restart after the flash sequence reuses the reset values.
    always_ff @(posedge clk) begin
        if (reset || restart_now) begin
            state_reg     <= ST_PLAY;
            level_reg     <= '0;
            width_reg     <= WW'(INIT_WIDTH);
            pos_reg       <= '0;
            dir_reg       <= 1'b1;
            phase_reg     <= 1'b0;
            flash_cnt_reg <= '0;
            for (int r = 0; r < ROWS; r++)
                stack_reg[r] <= '0;
        end else if (state_reg == ST_PLAY) begin
            // A drop wins over a same-cycle move: the pre-move mask is used.
            if (drop) begin
                if (ovl == '0) begin
                    state_reg <= ST_LOSE;
                end else begin
                    for (int r = 0; r < ROWS; r++)
                        if (r == int'(level_reg))
                            stack_reg[r] <= ovl;
                    width_reg <= ovl_count;
                    level_reg <= level_reg + LW'(1);
                    pos_reg   <= '0;
                    dir_reg   <= 1'b1;
                    if (level_reg == LW'(ROWS - 1))
                        state_reg <= ST_WIN;
                end
            end else if (step_en) begin
                pos_reg <= pos_moved;
                dir_reg <= dir_moved;
            end
        end else if (blink_tick) begin
            phase_reg     <= ~phase_reg;
            flash_cnt_reg <= flash_cnt_reg + FW'(1);
        end
    end

    // Image content of the row currently being scanned. In LOSE the
    // failed slider stays visible on its row, blinking with the rest.
    always_comb begin
        row_pix = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r == int'(scan_reg)) begin
                if (r < int'(level_reg))
                    row_pix = stack_reg[r];
                else if (r == int'(level_reg) && state_reg != ST_WIN)
                    row_pix = slider_mask;
            end
        end
        if (state_reg != ST_PLAY && !phase_reg)
            row_pix = '0;
    end

    // Display scan keeps running across restarts so the matrix never blanks.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_reg    <= '0;
            col_out_reg <= '0;
            row_sel_reg <= '1;
        end else begin
            if (scan_tick)
                scan_reg <= (int'(scan_reg) == ROWS - 1) ? '0 : scan_reg + SW'(1);
            col_out_reg <= row_pix;
            row_sel_reg <= ~(ROWS'(1) << scan_reg);
        end
    end

    assign col_out = col_out_reg;
    assign row_sel = row_sel_reg;
    assign level   = level_reg;
    assign state   = state_reg;
    assign width   = width_reg;

endmodule

// File: tb/tb_stacker_core.sv
// -----------------------------------------------------------------------------
// tb_stacker_core
//   Directed bench for stacker_core with default parameters (8x8, width 3,
//   8 flash pairs). Slider position is observed through the display by
//   scanning to the slider's row and reading col_out.
// -----------------------------------------------------------------------------
module tb_stacker_core;
    logic       clk = 1'b0;
    logic       reset;
    logic       move_tick;
    logic       scan_tick;
    logic       blink_tick;
    logic       drop;
    logic [7:0] col_out;
    logic [7:0] row_sel;
    logic [3:0] level;
    logic [1:0] state;
    logic [3:0] width;

    int n_checks = 0;
    int n_errors = 0;
    int tb_scan  = 0;

    stacker_core #(
        .COLS(8), .ROWS(8), .INIT_WIDTH(3), .FLASH_TICKS(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .move_tick  (move_tick),
        .scan_tick  (scan_tick),
        .blink_tick (blink_tick),
        .drop       (drop),
        .col_out    (col_out),
        .row_sel    (row_sel),
        .level      (level),
        .state      (state),
        .width      (width)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic pulse(input logic m, input logic d, input logic s, input logic b);
        move_tick  = m;
        drop       = d;
        scan_tick  = s;
        blink_tick = b;
        @(negedge clk);
        move_tick  = 1'b0;
        drop       = 1'b0;
        scan_tick  = 1'b0;
        blink_tick = 1'b0;
    endtask

    task automatic moves(input int n);
        for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_row(input int r, output logic [7:0] v);
        while (tb_scan != r) begin
            pulse(1'b0, 1'b0, 1'b1, 1'b0);
            tb_scan = (tb_scan + 1) % 8;
        end
        @(negedge clk);
        v = col_out;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        tb_scan = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        reset = 1'b1; move_tick = 1'b0; scan_tick = 1'b0; blink_tick = 1'b0; drop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_state",   state,   2'd0);
        check("rst_level",   level,   4'd0);
        check("rst_width",   width,   4'd3);
        check("rst_col_out", col_out, 8'h00);
        check("rst_row_sel", row_sel, 8'hFF);
        reset = 1'b0;
        tb_scan = 0;

        // Bounce
        moves(5);  read_row(0, v); check("bounce_pos5",  v, 8'b11100000);
        moves(1);  read_row(0, v); check("bounce_pos4",  v, 8'b01110000);
        moves(4);  read_row(0, v); check("bounce_pos0",  v, 8'b00000111);
        moves(1);  read_row(0, v); check("bounce_pos1",  v, 8'b00001110);

        // First drop at pos 2
        moves(1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("drop1_level", level, 4'd1);
        check("drop1_width", width, 4'd3);
        read_row(0, v); check("drop1_row0",  v, 8'b00011100);
        read_row(1, v); check("drop1_slide", v, 8'b00000111);

        // Trim at pos 3
        moves(3);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("trim_level", level, 4'd2);
        check("trim_width", width, 4'd2);
        read_row(1, v); check("trim_row1",  v, 8'b00011000);
        read_row(2, v); check("trim_slide", v, 8'b00000011);

        // Loss at pos 0, then ignored inputs, blink and restart
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("lose_state", state, 2'd2);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("lose_drop_ign_level", level, 4'd2);
        check("lose_drop_ign_state", state, 2'd2);
        read_row(0, v); check("lose_ph0_row0", v, 8'h00);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        read_row(0, v); check("lose_ph1_row0", v, 8'b00011100);
        read_row(2, v); check("lose_ph1_fail", v, 8'b00000011);
        for (int i = 0; i < 14; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("lose_15_state", state, 2'd2);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("restart_state", state, 2'd0);
        check("restart_level", level, 4'd0);
        check("restart_width", width, 4'd3);
        read_row(0, v); check("restart_row0", v, 8'b00000111);
        read_row(1, v); check("restart_row1", v, 8'h00);

        // Drop and move in the same cycle at pos 4
        moves(4);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("dm_level", level, 4'd1);
        read_row(0, v); check("dm_row0",  v, 8'b01110000);
        read_row(1, v); check("dm_slide", v, 8'b00000111);

        // Win with eight aligned drops
        do_reset();
        for (int i = 0; i < 7; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("win7_state", state, 2'd0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("win_state", state, 2'd1);
        check("win_level", level, 4'd8);
        check("win_width", width, 4'd3);
        read_row(7, v); check("win_ph0_row7", v, 8'h00);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        read_row(7, v); check("win_ph1_row7", v, 8'b00000111);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        read_row(7, v); check("win_ph0b_row7", v, 8'h00);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of the flash
        reset = 1'b1;
        @(negedge clk);
        check("midrst_state",   state,   2'd0);
        check("midrst_level",   level,   4'd0);
        check("midrst_width",   width,   4'd3);
        check("midrst_col_out", col_out, 8'h00);
        check("midrst_row_sel", row_sel, 8'hFF);
        reset = 1'b0;
        tb_scan = 0;

        // Scan walk
        @(negedge clk);
        check("scan_0", row_sel, 8'hFE);
        for (int k = 1; k <= 8; k++) begin
            logic [7:0] exp_sel;
            pulse(1'b0, 1'b0, 1'b1, 1'b0);
            tb_scan = k % 8;
            @(negedge clk);
            exp_sel = 8'd1 << (k % 8);
            exp_sel = ~exp_sel;
            check($sformatf("scan_%0d", k), row_sel, exp_sel);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
